// File: rtl/sr_timer_pkg.sv
// Shared types and default widths for the start/stop down-counting timer.
// Optional periodic mode is enabled with the SR_TIMER_AUTORELOAD_EN macro.
package sr_timer_pkg;

  localparam int DEF_WIDTH      = 16;
  localparam int DEF_PRESCALE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } timer_state_e;

endpackage

// File: rtl/sr_prescaler.sv
// Rate divider for the down timer: tick every prescale+1 enabled cycles.
// Holds its phase while disabled, so a paused run resumes mid-period.
module sr_prescaler
  import sr_timer_pkg::*;
#(
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic                  clear_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  tick_o
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  // >= rather than == so a mid-run decrease of prescale ticks right away
  assign tick_o = enable_i && (cnt_q >= prescale_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || tick_o) cnt_d = '0;
    else if (enable_i)     cnt_d = cnt_q + PRESCALE_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sr_down_timer.sv
// Loadable start/stop down timer with prescaler and one-cycle expired pulse.
// Define SR_TIMER_AUTORELOAD_EN for periodic reload from the last loaded value.
module sr_down_timer
  import sr_timer_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  load_i,
  input  logic [WIDTH-1:0]      load_value_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic [WIDTH-1:0]      count_o,
  output logic                  running_o,
  output logic                  expired_o,
  output logic                  done_o
);

  timer_state_e     state_q;
  logic [WIDTH-1:0] count_q, count_dec_d;
  logic             running_q, expired_q, done_q;
  logic             tick, presc_en, presc_clr, start_ok, is_last;
`ifdef SR_TIMER_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q;
`endif

  // stop beats start whenever both are present
  assign start_ok    = start_i && !stop_i;
  assign presc_en    = (state_q == ST_RUN) && !load_i && !stop_i;
  assign presc_clr   = load_i || ((state_q == ST_IDLE) && start_ok);
  assign count_dec_d = count_q - WIDTH'(1);
  assign is_last     = (count_q == WIDTH'(1));

  sr_prescaler #(.PRESCALE_W(PRESCALE_W)) u_presc (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .enable_i   (presc_en),
    .clear_i    (presc_clr),
    .prescale_i (prescale_i),
    .tick_o     (tick)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef SR_TIMER_AUTORELOAD_EN
      reload_q  <= '0;
`endif
    end else begin
      expired_q <= 1'b0;
      if (load_i) begin
        state_q   <= ST_IDLE;
        count_q   <= load_value_i;
        running_q <= 1'b0;
        done_q    <= 1'b0;
`ifdef SR_TIMER_AUTORELOAD_EN
        reload_q  <= load_value_i;
`endif
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (start_ok) begin
              if (count_q != '0) begin
                state_q   <= ST_RUN;
                running_q <= 1'b1;
              end else begin
                state_q   <= ST_DONE;
                done_q    <= 1'b1;
                expired_q <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (stop_i) begin
              state_q   <= ST_PAUSE;
              running_q <= 1'b0;
            end else if (tick && count_q != '0) begin
              if (is_last) begin
                expired_q <= 1'b1;
`ifdef SR_TIMER_AUTORELOAD_EN
                if (reload_q != '0) begin
                  count_q <= reload_q;
                end else begin
                  count_q   <= '0;
                  state_q   <= ST_DONE;
                  running_q <= 1'b0;
                  done_q    <= 1'b1;
                end
`else
                count_q   <= '0;
                state_q   <= ST_DONE;
                running_q <= 1'b0;
                done_q    <= 1'b1;
`endif
              end else begin
                count_q <= count_dec_d;
              end
            end
          end
          ST_PAUSE: begin
            if (start_ok) begin
              state_q   <= ST_RUN;
              running_q <= 1'b1;
            end
          end
          ST_DONE: begin
            // only load or reset leave DONE
            count_q <= '0;
          end
          default: begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count_o   = count_q;
  assign running_o = running_q;
  assign expired_o = expired_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_sr_down_timer.sv
// Scoreboard bench for sr_down_timer: each stimulus row pushes its expected
// post-edge outputs, which are popped and compared one step after the edge.
module tb_sr_down_timer;

  typedef struct packed {
    logic        rst;
    logic        ld;
    logic [15:0] lv;
    logic        st;
    logic        sp;
    logic [7:0]  ps;
  } stim_t;

  typedef struct packed {
    logic [15:0] cnt;
    logic        run;
    logic        exp;
    logic        dn;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset, load, start, stop;
  logic [15:0] load_value;
  logic [7:0]  prescale;
  logic [15:0] count;
  logic        running, expired, done;

  obs_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  sr_down_timer dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .load_i       (load),
    .load_value_i (load_value),
    .start_i      (start),
    .stop_i       (stop),
    .prescale_i   (prescale),
    .count_o      (count),
    .running_o    (running),
    .expired_o    (expired),
    .done_o       (done)
  );

  function automatic stim_t mk_s(input logic rst, input logic ld, input logic [15:0] lv,
                                 input logic st, input logic sp, input logic [7:0] ps);
    stim_t s;
    s.rst = rst; s.ld = ld; s.lv = lv; s.st = st; s.sp = sp; s.ps = ps;
    return s;
  endfunction

  function automatic obs_t mk_o(input logic [15:0] c, input logic r, input logic x, input logic d);
    obs_t o;
    o.cnt = c; o.run = r; o.exp = x; o.dn = d;
    return o;
  endfunction

  task automatic apply(input stim_t s);
    reset = s.rst; load = s.ld; load_value = s.lv;
    start = s.st;  stop = s.sp; prescale   = s.ps;
  endtask

  task automatic test_reset();
    stim_t sq[$]; obs_t eq[$]; obs_t got, want;
    sq.push_back(mk_s(1, 0, 16'd0, 0, 0, 8'd0)); eq.push_back(mk_o(0, 0, 0, 0));
    sq.push_back(mk_s(1, 1, 16'd9, 1, 0, 8'd0)); eq.push_back(mk_o(0, 0, 0, 0));
    foreach (sq[i]) begin
      apply(sq[i]); sb_q.push_back(eq[i]);
      @(posedge clk); #1;
      want = sb_q.pop_front(); got = {count, running, expired, done};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL reset row %0d: got cnt=%0d run=%b exp=%b done=%b, want cnt=%0d run=%b exp=%b done=%b",
                 i, got.cnt, got.run, got.exp, got.dn, want.cnt, want.run, want.exp, want.dn);
      end
    end
  endtask

  task automatic test_oneshot();
    stim_t sq[$]; obs_t eq[$]; obs_t got, want;
    sq.push_back(mk_s(0, 1, 16'd3, 0, 0, 8'd0)); eq.push_back(mk_o(3, 0, 0, 0));
    sq.push_back(mk_s(0, 0, 16'd0, 1, 0, 8'd0)); eq.push_back(mk_o(3, 1, 0, 0));
    sq.push_back(mk_s(0, 0, 16'd0, 0, 0, 8'd0)); eq.push_back(mk_o(2, 1, 0, 0));
    sq.push_back(mk_s(0, 0, 16'd0, 0, 0, 8'd0)); eq.push_back(mk_o(1, 1, 0, 0));
    sq.push_back(mk_s(0, 0, 16'd0, 0, 0, 8'd0)); eq.push_back(mk_o(0, 0, 1, 1));
    sq.push_back(mk_s(0, 0, 16'd0, 0, 0, 8'd0)); eq.push_back(mk_o(0, 0, 0, 1));
    foreach (sq[i]) begin
      apply(sq[i]); sb_q.push_back(eq[i]);
      @(posedge clk); #1;
      want = sb_q.pop_front(); got = {count, running, expired, done};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL oneshot row %0d: got cnt=%0d run=%b exp=%b done=%b, want cnt=%0d run=%b exp=%b done=%b",
                 i, got.cnt, got.run, got.exp, got.dn, want.cnt, want.run, want.exp, want.dn);
      end
    end
  endtask

  task automatic test_prescale();
    stim_t sq[$]; obs_t eq[$]; obs_t got, want;
    sq.push_back(mk_s(0, 1, 16'd2, 0, 0, 8'd3)); eq.push_back(mk_o(2, 0, 0, 0));
    sq.push_back(mk_s(0, 0, 16'd0, 1, 0, 8'd3)); eq.push_back(mk_o(2, 1, 0, 0));
    for (int k = 1; k <= 8; k++) begin
      sq.push_back(mk_s(0, 0, 16'd0, 0, 0, 8'd3));
      if (k < 4)       eq.push_back(mk_o(2, 1, 0, 0));
      else if (k < 8)  eq.push_back(mk_o(1, 1, 0, 0));
      else             eq.push_back(mk_o(0, 0, 1, 1));
    end
    foreach (sq[i]) begin
      apply(sq[i]); sb_q.push_back(eq[i]);
      @(posedge clk); #1;
      want = sb_q.pop_front(); got = {count, running, expired, done};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL prescale row %0d: got cnt=%0d run=%b exp=%b done=%b, want cnt=%0d run=%b exp=%b done=%b",
                 i, got.cnt, got.run, got.exp, got.dn, want.cnt, want.run, want.exp, want.dn);
      end
    end
  endtask

  task automatic test_pause();
    stim_t sq[$]; obs_t eq[$]; obs_t got, want;
    sq.push_back(mk_s(0, 1, 16'd5, 0, 0, 8'd0)); eq.push_back(mk_o(5, 0, 0, 0));
    sq.push_back(mk_s(0, 0, 16'd0, 1, 0, 8'd0)); eq.push_back(mk_o(5, 1, 0, 0));
    sq.push_back(mk_s(0, 0, 16'd0, 0, 0, 8'd0)); eq.push_back(mk_o(4, 1, 0, 0));
    sq.push_back(mk_s(0, 0, 16'd0, 0, 0, 8'd0)); eq.push_back(mk_o(3, 1, 0, 0));
    sq.push_back(mk_s(0, 0, 16'd0, 0, 1, 8'd0)); eq.push_back(mk_o(3, 0, 0, 0));
    for (int k = 0; k < 4; k++) begin
      sq.push_back(mk_s(0, 0, 16'd0, 0, 0, 8'd0)); eq.push_back(mk_o(3, 0, 0, 0));
    end
    sq.push_back(mk_s(0, 0, 16'd0, 1, 1, 8'd0)); eq.push_back(mk_o(3, 0, 0, 0));
    sq.push_back(mk_s(0, 0, 16'd0, 1, 0, 8'd0)); eq.push_back(mk_o(3, 1, 0, 0));
    sq.push_back(mk_s(0, 0, 16'd0, 0, 0, 8'd0)); eq.push_back(mk_o(2, 1, 0, 0));
    sq.push_back(mk_s(0, 0, 16'd0, 1, 1, 8'd0)); eq.push_back(mk_o(2, 0, 0, 0));
    sq.push_back(mk_s(0, 0, 16'd0, 1, 0, 8'd0)); eq.push_back(mk_o(2, 1, 0, 0));
    sq.push_back(mk_s(0, 0, 16'd0, 0, 0, 8'd0)); eq.push_back(mk_o(1, 1, 0, 0));
    sq.push_back(mk_s(0, 0, 16'd0, 0, 0, 8'd0)); eq.push_back(mk_o(0, 0, 1, 1));
    sq.push_back(mk_s(0, 0, 16'd0, 0, 0, 8'd0)); eq.push_back(mk_o(0, 0, 0, 1));
    foreach (sq[i]) begin
      apply(sq[i]); sb_q.push_back(eq[i]);
      @(posedge clk); #1;
      want = sb_q.pop_front(); got = {count, running, expired, done};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL pause row %0d: got cnt=%0d run=%b exp=%b done=%b, want cnt=%0d run=%b exp=%b done=%b",
                 i, got.cnt, got.run, got.exp, got.dn, want.cnt, want.run, want.exp, want.dn);
      end
    end
  endtask

  task automatic test_zero_start();
    stim_t sq[$]; obs_t eq[$]; obs_t got, want;
    sq.push_back(mk_s(1, 0, 16'd0, 0, 0, 8'd0)); eq.push_back(mk_o(0, 0, 0, 0));
    sq.push_back(mk_s(0, 0, 16'd0, 1, 0, 8'd0)); eq.push_back(mk_o(0, 0, 1, 1));
    sq.push_back(mk_s(0, 0, 16'd0, 0, 0, 8'd0)); eq.push_back(mk_o(0, 0, 0, 1));
    sq.push_back(mk_s(0, 0, 16'd0, 1, 0, 8'd0)); eq.push_back(mk_o(0, 0, 0, 1));
    sq.push_back(mk_s(0, 0, 16'd0, 1, 1, 8'd0)); eq.push_back(mk_o(0, 0, 0, 1));
    sq.push_back(mk_s(0, 1, 16'd7, 0, 0, 8'd0)); eq.push_back(mk_o(7, 0, 0, 0));
    sq.push_back(mk_s(0, 0, 16'd0, 0, 0, 8'd0)); eq.push_back(mk_o(7, 0, 0, 0));
    foreach (sq[i]) begin
      apply(sq[i]); sb_q.push_back(eq[i]);
      @(posedge clk); #1;
      want = sb_q.pop_front(); got = {count, running, expired, done};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL zero_start row %0d: got cnt=%0d run=%b exp=%b done=%b, want cnt=%0d run=%b exp=%b done=%b",
                 i, got.cnt, got.run, got.exp, got.dn, want.cnt, want.run, want.exp, want.dn);
      end
    end
  endtask

  task automatic test_reset_mid();
    stim_t sq[$]; obs_t eq[$]; obs_t got, want;
    sq.push_back(mk_s(0, 1, 16'd6, 0, 0, 8'd0)); eq.push_back(mk_o(6, 0, 0, 0));
    sq.push_back(mk_s(0, 0, 16'd0, 1, 0, 8'd0)); eq.push_back(mk_o(6, 1, 0, 0));
    sq.push_back(mk_s(0, 0, 16'd0, 0, 0, 8'd0)); eq.push_back(mk_o(5, 1, 0, 0));
    sq.push_back(mk_s(0, 0, 16'd0, 0, 0, 8'd0)); eq.push_back(mk_o(4, 1, 0, 0));
    sq.push_back(mk_s(1, 0, 16'd0, 0, 0, 8'd0)); eq.push_back(mk_o(0, 0, 0, 0));
    sq.push_back(mk_s(0, 0, 16'd0, 0, 0, 8'd0)); eq.push_back(mk_o(0, 0, 0, 0));
    sq.push_back(mk_s(0, 0, 16'd0, 0, 0, 8'd0)); eq.push_back(mk_o(0, 0, 0, 0));
    foreach (sq[i]) begin
      apply(sq[i]); sb_q.push_back(eq[i]);
      @(posedge clk); #1;
      want = sb_q.pop_front(); got = {count, running, expired, done};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL reset_mid row %0d: got cnt=%0d run=%b exp=%b done=%b, want cnt=%0d run=%b exp=%b done=%b",
                 i, got.cnt, got.run, got.exp, got.dn, want.cnt, want.run, want.exp, want.dn);
      end
    end
  endtask

  task automatic test_prescale_drop();
    stim_t sq[$]; obs_t eq[$]; obs_t got, want;
    sq.push_back(mk_s(0, 1, 16'd3, 0, 0, 8'd5)); eq.push_back(mk_o(3, 0, 0, 0));
    sq.push_back(mk_s(0, 0, 16'd0, 1, 0, 8'd5)); eq.push_back(mk_o(3, 1, 0, 0));
    for (int k = 0; k < 3; k++) begin
      sq.push_back(mk_s(0, 0, 16'd0, 0, 0, 8'd5)); eq.push_back(mk_o(3, 1, 0, 0));
    end
    sq.push_back(mk_s(0, 0, 16'd0, 0, 0, 8'd1)); eq.push_back(mk_o(2, 1, 0, 0));
    sq.push_back(mk_s(0, 0, 16'd0, 0, 0, 8'd1)); eq.push_back(mk_o(2, 1, 0, 0));
    sq.push_back(mk_s(0, 0, 16'd0, 0, 0, 8'd1)); eq.push_back(mk_o(1, 1, 0, 0));
    sq.push_back(mk_s(0, 0, 16'd0, 0, 0, 8'd1)); eq.push_back(mk_o(1, 1, 0, 0));
    sq.push_back(mk_s(0, 0, 16'd0, 0, 0, 8'd1)); eq.push_back(mk_o(0, 0, 1, 1));
    foreach (sq[i]) begin
      apply(sq[i]); sb_q.push_back(eq[i]);
      @(posedge clk); #1;
      want = sb_q.pop_front(); got = {count, running, expired, done};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL prescale_drop row %0d: got cnt=%0d run=%b exp=%b done=%b, want cnt=%0d run=%b exp=%b done=%b",
                 i, got.cnt, got.run, got.exp, got.dn, want.cnt, want.run, want.exp, want.dn);
      end
    end
  endtask

  task automatic test_load_priority();
    stim_t sq[$]; obs_t eq[$]; obs_t got, want;
    sq.push_back(mk_s(0, 1, 16'd4, 0, 0, 8'd0)); eq.push_back(mk_o(4, 0, 0, 0));
    sq.push_back(mk_s(0, 0, 16'd0, 1, 0, 8'd0)); eq.push_back(mk_o(4, 1, 0, 0));
    sq.push_back(mk_s(0, 1, 16'd9, 1, 1, 8'd0)); eq.push_back(mk_o(9, 0, 0, 0));
    sq.push_back(mk_s(0, 0, 16'd0, 0, 0, 8'd0)); eq.push_back(mk_o(9, 0, 0, 0));
    sq.push_back(mk_s(0, 1, 16'd1, 0, 0, 8'd0)); eq.push_back(mk_o(1, 0, 0, 0));
    sq.push_back(mk_s(0, 0, 16'd0, 1, 0, 8'd0)); eq.push_back(mk_o(1, 1, 0, 0));
`ifdef SR_TIMER_AUTORELOAD_EN
    sq.push_back(mk_s(0, 0, 16'd0, 0, 0, 8'd0)); eq.push_back(mk_o(1, 1, 1, 0));
`else
    sq.push_back(mk_s(0, 0, 16'd0, 0, 0, 8'd0)); eq.push_back(mk_o(0, 0, 1, 1));
`endif
    foreach (sq[i]) begin
      apply(sq[i]); sb_q.push_back(eq[i]);
      @(posedge clk); #1;
      want = sb_q.pop_front(); got = {count, running, expired, done};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL load_priority row %0d: got cnt=%0d run=%b exp=%b done=%b, want cnt=%0d run=%b exp=%b done=%b",
                 i, got.cnt, got.run, got.exp, got.dn, want.cnt, want.run, want.exp, want.dn);
      end
    end
  endtask

`ifdef SR_TIMER_AUTORELOAD_EN
  task automatic test_autoreload();
    stim_t sq[$]; obs_t eq[$]; obs_t got, want;
    sq.push_back(mk_s(0, 1, 16'd2, 0, 0, 8'd0)); eq.push_back(mk_o(2, 0, 0, 0));
    sq.push_back(mk_s(0, 0, 16'd0, 1, 0, 8'd0)); eq.push_back(mk_o(2, 1, 0, 0));
    for (int k = 0; k < 6; k++) begin
      sq.push_back(mk_s(0, 0, 16'd0, 0, 0, 8'd0));
      if (k % 2 == 0) eq.push_back(mk_o(1, 1, 0, 0));
      else            eq.push_back(mk_o(2, 1, 1, 0));
    end
    foreach (sq[i]) begin
      apply(sq[i]); sb_q.push_back(eq[i]);
      @(posedge clk); #1;
      want = sb_q.pop_front(); got = {count, running, expired, done};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL autoreload row %0d: got cnt=%0d run=%b exp=%b done=%b, want cnt=%0d run=%b exp=%b done=%b",
                 i, got.cnt, got.run, got.exp, got.dn, want.cnt, want.run, want.exp, want.dn);
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b1; load = 1'b0; load_value = '0;
    start = 1'b0; stop = 1'b0; prescale = '0;
    test_reset();
    test_oneshot();
    test_prescale();
    test_pause();
    test_zero_start();
    test_reset_mid();
    test_prescale_drop();
    test_load_priority();
`ifdef SR_TIMER_AUTORELOAD_EN
    test_autoreload();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sr_down_timer.md
# sr_down_timer

Loadable start/stop down-counting timer, the countdown counterpart of the up-counting start/stop counter. Firmware or a control FSM loads a 16-bit interval, starts it, and receives a one-cycle `expired` pulse when the count reaches zero. A programmable prescaler sets the decrement rate. The block sits beside the up-counter on the same clock domain and uses the same start/stop control style.

## Interface
- `WIDTH`, default 16: counter width.
- `PRESCALE_W`, default 8: prescaler width.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `load` in 1: capture `load_value` into the count (and into the reload register).
- `load_value` in WIDTH: interval to load.
- `start` in 1: begin or resume counting.
- `stop` in 1: pause counting.
- `prescale` in PRESCALE_W: one decrement every `prescale+1` cycles.
- `count` out WIDTH: current remaining count.
- `running` out 1: high in RUN.
- `expired` out 1: one-cycle pulse when the count reaches 0.
- `done` out 1: level, high in DONE.

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- Priority at each edge: `reset` > `load` > `stop` > `start` > tick.
- Reset values: state IDLE, `count`=0, prescaler=0, reload register=0, `running`=0, `expired`=0, `done`=0.
- `load`, from any state: `count`<=`load_value`; reload register<=`load_value`; prescaler<=0; state IDLE.
- IDLE + `start`, `count`!=0: go to RUN with prescaler=0.
- IDLE + `start`, `count`==0: go to DONE and pulse `expired`.
- IDLE + tick: ignored.
- RUN: prescaler increments each cycle.
  - When prescaler>=`prescale`, prescaler<=0 and `count`<=`count`-1.
  - A decrement from 1 to 0 pulses `expired`. State then goes to DONE, except under the macro (see Configuration).
- RUN + `stop`: go to PAUSE. Prescaler and `count` hold.
- PAUSE + `start`: go to RUN. The prescaler resumes from its held value.
- `start` and `stop` asserted together: `stop` wins. RUN goes to PAUSE; IDLE and PAUSE are unchanged.
- DONE: `count` holds 0. `start` and `stop` are ignored. Only `load` or `reset` exits.
- `count` never wraps. A decrement is never applied at 0.
- `prescale` is sampled every cycle. A mid-run decrease that leaves prescaler>=`prescale` produces a tick on the next cycle.

## Timing
- All outputs are registered.
- `running` rises the edge after `start` is sampled.
- With `load_value`=N and `prescale`=P, `expired` and `count`==0 appear exactly N*(P+1) edges after the edge that entered RUN, excluding paused cycles.
- `expired` is high for exactly one cycle.
- `done` rises on the same edge as `expired` and stays high until `load` or `reset`.
- `load` takes effect on the next edge. `count` reflects `load_value` one cycle after `load` is sampled.
- `reset` mid-run: all outputs return to reset values on the next edge. No `expired` pulse is produced.

## Configuration
- Macro: `SR_TIMER_AUTORELOAD_EN`.
- Defined:
  - On a 1→0 decrement in RUN, `count`<=reload register and state stays RUN; `expired` still pulses each period.
  - DONE is reached only if the reload register is 0.
  - Periodic output: one `expired` pulse every N*(P+1) cycles.
- Undefined: one-shot behaviour as in Operation. The reload register is absent, and `load` affects only `count`.

## Structure
- Package `sr_timer_pkg` holds:
  - the state enum (IDLE, RUN, PAUSE, DONE);
  - default `WIDTH` and `PRESCALE_W` constants.
- Sub-module `sr_prescaler` holds:
  - inputs `clk`, `reset`, `enable`, `clear`, `prescale`;
  - output `tick`.
  - It holds its value when `enable` is low.
- The top level holds the FSM, the count register and, under the macro, the reload register.

## Test plan
- `load_value`=3, `prescale`=0, `start` → `count` sequence 3,2,1,0 on consecutive edges; `expired` one cycle with `count`=0; `done`=1; `running`=0.
- `load_value`=2, `prescale`=3, `start` → decrements every 4 cycles; `expired` 8 edges after RUN entry.
- `load_value`=5, `prescale`=0: `stop` when `count`=3, hold 4 cycles, `start` → `count` stays 3 while paused, then continues 2,1,0. `start` and `stop` in the same cycle during RUN → PAUSE.
- `start` with `count`=0 after reset → DONE and a single `expired` pulse. `start` in DONE → no change. `load` 7 in DONE → IDLE, `count`=7, `done`=0.
- `reset` asserted mid-count at `count`=4 → next edge `count`=0, `running`=0, no `expired`.
- With `SR_TIMER_AUTORELOAD_EN`, `load_value`=2, `prescale`=0, `start` → `expired` every 2 cycles, `count` 2,1,2,1…, `done` never set.
